// File: rtl/rot_pkg.sv
// rot_pkg: shared types for the rot_pipe rotate/shift pipeline
// Holds the operation encoding and the payload carried between stages.
// The payload is sized for the largest supported configuration; each
// pipeline instance uses only the low WIDTH / LEVELS / TAG_W bits and
// carries the unused upper bits through untouched.
package rot_pkg;

   localparam int MAX_W   = 64;
   localparam int MAX_LV  = 6;
   localparam int MAX_TAG = 32;

   typedef enum logic [2:0] {
      ROTR  = 3'd0,
      ROTL  = 3'd1,
      SHR   = 3'd2,
      SHL   = 3'd3,
      SAR   = 3'd4,
      PASS5 = 3'd5,
      PASS6 = 3'd6,
      PASS7 = 3'd7
   } rot_mode_t;

   typedef struct packed {
      logic [MAX_W-1:0]   data;
      logic [MAX_LV-1:0]  amt;
      rot_mode_t          mode;
      logic [MAX_TAG-1:0] tag;
      logic               valid;
   } rot_payload_t;

endpackage

// File: rtl/rot_stage.sv
// rot_stage: one level of the rotate/shift pipeline
// Applies a 2^K-bit step when amount bit K is set, then registers the payload.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the whole register
//   adv   : advance enable; register holds when low
//   d     : payload from the previous stage
//   q     : registered payload for the next stage
module rot_stage
   import rot_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         adv,
   input  rot_payload_t d,
   output rot_payload_t q
);

   localparam int S = 2 ** K;

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   rot_payload_t     nxt;

   // SAR keeps the sign bit at every level, so each stage can refill from
   // its own MSB and still match the original operand's sign.
   always_comb begin
      x = d.data[WIDTH-1:0];
      y = x;
      if (d.amt[K])
         case (d.mode)
            ROTR:    y = (x >> S) | (x << (WIDTH - S));
            ROTL:    y = (x << S) | (x >> (WIDTH - S));
            SHR:     y = x >> S;
            SHL:     y = x << S;
            SAR:     y = $signed(x) >>> S;
            default: y = x;
         endcase
      nxt = d;
      nxt.data[WIDTH-1:0] = y;
   end

   always_ff @(posedge clk)
      if (!rst_n)
         q <= '0;
      else if (adv)
         q <= nxt;

endmodule

// File: rtl/rot_pipe.sv
// rot_pipe: LEVELS-deep pipelined rotate/shift unit with valid/ready handshake
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_data, in_amt       : operand and shift/rotate amount
//   in_mode, in_tag       : operation (rot_mode_t) and opaque sideband tag
//   out_valid / out_ready : result handshake
//   out_data, out_tag     : registered result and the tag of its request
module rot_pipe
   import rot_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int TAG_W  = 4,
   localparam int LEVELS = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [LEVELS-1:0] in_amt,
   input  logic [2:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [TAG_W-1:0]  out_tag
);

   logic         adv;
   rot_payload_t head;
   rot_payload_t chain [LEVELS+1];

   // The whole pipe moves as one; a stalled output freezes every stage,
   // which keeps in_ready free of any path from in_* signals.
   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n && adv;

   always_comb begin
      head                    = '0;
      head.data[WIDTH-1:0]    = in_data;
      head.amt[LEVELS-1:0]    = in_amt;
      head.mode               = rot_mode_t'(in_mode);
      head.tag[TAG_W-1:0]     = in_tag;
      head.valid              = in_valid && in_ready;
   end

   assign chain[0] = head;

   for (genvar k = 0; k < LEVELS; k++) begin : g_stage
      rot_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .adv   (adv),
         .d     (chain[k]),
         .q     (chain[k+1])
      );
   end

   assign out_valid = chain[LEVELS].valid;
   assign out_data  = chain[LEVELS].data[WIDTH-1:0];
   assign out_tag   = chain[LEVELS].tag[TAG_W-1:0];

endmodule

// File: tb/tb_rot_pipe.sv
// tb_rot_pipe: directed and randomised checks of rot_pipe at WIDTH=32 and WIDTH=8
module tb_rot_pipe;
   import rot_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic        iv, ir, ov, ordy;
   logic [31:0] id, od;
   logic [4:0]  ia;
   logic [2:0]  im;
   logic [3:0]  it, ot;

   logic        iv8, ir8, ov8, ordy8;
   logic [7:0]  id8, od8;
   logic [2:0]  ia8;
   logic [2:0]  im8;
   logic [3:0]  it8, ot8;

   rot_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv), .in_ready(ir), .in_data(id), .in_amt(ia), .in_mode(im), .in_tag(it),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(ot)
   );

   rot_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8), .in_mode(im8), .in_tag(it8),
      .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_tag(ot8)
   );

   function automatic logic [7:0] ref8(logic [7:0] d, logic [2:0] a, logic [2:0] m);
      logic [7:0] r;
      int ai;
      ai = int'(a);
      r = '0;
      for (int i = 0; i < 8; i++)
         case (m)
            3'd0:    r[i] = d[(i + ai) % 8];
            3'd1:    r[i] = d[(i - ai + 8) % 8];
            3'd2:    r[i] = (i + ai < 8) ? d[(i + ai) % 8] : 1'b0;
            3'd3:    r[i] = (i >= ai) ? d[(i - ai + 8) % 8] : 1'b0;
            3'd4:    r[i] = (i + ai < 8) ? d[(i + ai) % 8] : d[7];
            default: r[i] = d[i];
         endcase
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      iv = 1'b0; id = '0; ia = '0; im = '0; it = '0; ordy = 1'b1;
      iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; it8 = '0; ordy8 = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (ir !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", ir); end
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov); end
      tests++; if (od !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", od); end
      tests++; if (ot !== 4'h0) begin fails++; $display("FAIL reset_out_tag: got %h want 0", ot); end
      tests++; if (ov8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid8: got %b want 0", ov8); end
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (ir !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", ir); end
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL release_out_valid: got %b want 0", ov); end
   endtask

   task automatic test_rotr();
      int lat;
      lat = -1;
      @(negedge clk);
      iv = 1'b1; id = 32'h12345678; ia = 5'd13; im = ROTR; it = 4'h3; ordy = 1'b1;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         @(negedge clk);
         iv = 1'b0;
         if (ov) begin
            lat = c;
            tests++; if (od !== 32'hB3C091A2) begin fails++; $display("FAIL rotr_data: got %h want b3c091a2", od); end
            tests++; if (ot !== 4'h3) begin fails++; $display("FAIL rotr_tag: got %h want 3", ot); end
         end
      end
      tests++; if (lat != 5) begin fails++; $display("FAIL rotr_latency: got %0d want 5", lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] din [4];
      logic [4:0]  amt [4];
      logic [2:0]  md  [4];
      logic [31:0] exp [4];
      int got, first, last;
      din = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h00000003};
      amt = '{5'd4, 5'd8, 5'd4, 5'd31};
      md  = '{ROTL, SHR, SAR, SHL};
      exp = '{32'h23456781, 32'h00123456, 32'hF8000000, 32'h80000000};
      got = 0; first = -1; last = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (ov) begin
            if (got == 0) first = c;
            last = c;
            tests++;
            if (got > 3) begin fails++; $display("FAIL b2b_extra: got %h want none", od); end
            else if (od !== exp[got] || ot !== 4'(got + 1)) begin
               fails++; $display("FAIL b2b_result%0d: got %h/%h want %h/%h", got, od, ot, exp[got], 4'(got + 1));
            end
            got++;
         end
         if (c < 4) begin iv = 1'b1; id = din[c]; ia = amt[c]; im = md[c]; it = 4'(c + 1); end
         else iv = 1'b0;
      end
      tests++; if (got != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", got); end
      tests++; if (last - first != 3) begin fails++; $display("FAIL b2b_consecutive: got span %0d want 3", last - first); end
   endtask

   task automatic test_backpressure();
      logic [31:0] din [5];
      logic [4:0]  amt [5];
      logic [2:0]  md  [5];
      logic [31:0] exp [5];
      int got;
      din = '{32'h000000F0, 32'h0000000F, 32'hF0000000, 32'h00000001, 32'h40000000};
      amt = '{5'd4, 5'd4, 5'd28, 5'd16, 5'd1};
      md  = '{ROTR, ROTL, SHR, SHL, SAR};
      exp = '{32'h0000000F, 32'h000000F0, 32'h0000000F, 32'h00010000, 32'h20000000};
      got = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ordy = !(c >= 5 && c <= 7);
         if (c < 5) begin iv = 1'b1; id = din[c]; ia = amt[c]; im = md[c]; it = 4'(c + 5); end
         else iv = 1'b0;
         #1;
         if (c >= 5 && c <= 7) begin
            tests++; if (ir !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, ir); end
            tests++; if (ov !== 1'b1 || od !== exp[0]) begin fails++; $display("FAIL bp_hold c%0d: got %b/%h want 1/%h", c, ov, od, exp[0]); end
         end
         if (ov && ordy) begin
            tests++;
            if (got > 4) begin fails++; $display("FAIL bp_extra: got %h want none", od); end
            else if (od !== exp[got] || ot !== 4'(got + 5)) begin
               fails++; $display("FAIL bp_result%0d: got %h/%h want %h/%h", got, od, ot, exp[got], 4'(got + 5));
            end
            got++;
         end
      end
      ordy = 1'b1;
      tests++; if (got != 5) begin fails++; $display("FAIL bp_count: got %0d want 5", got); end
   endtask

   task automatic test_boundaries();
      logic [31:0] din [9];
      logic [4:0]  amt [9];
      logic [2:0]  md  [9];
      int got;
      din = '{32'hA5C30F81, 32'h80000001, 32'hFFFF0000, 32'h0000FFFF, 32'h80000000,
              32'h12345678, 32'h0F0F0F0F, 32'h76543210, 32'hDEADBEEF};
      amt = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
      md  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
      got = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (ov) begin
            tests++;
            if (got > 8) begin fails++; $display("FAIL bound_extra: got %h want none", od); end
            else if (od !== din[got] || ot !== 4'(got)) begin
               fails++; $display("FAIL bound_result%0d: got %h/%h want %h/%h", got, od, ot, din[got], 4'(got));
            end
            got++;
         end
         if (c < 9) begin iv = 1'b1; id = din[c]; ia = amt[c]; im = md[c]; it = 4'(c); end
         else iv = 1'b0;
      end
      tests++; if (got != 9) begin fails++; $display("FAIL bound_count: got %0d want 9", got); end
   endtask

   task automatic test_reset_midflight();
      int seen, lat;
      seen = 0; lat = -1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         iv = 1'b1; id = 32'h11111111 << c; ia = 5'(c + 1); im = ROTL; it = 4'(c + 12);
      end
      @(negedge clk);
      iv = 1'b0; rst_n = 1'b0;
      #1;
      tests++; if (ir !== 1'b0) begin fails++; $display("FAIL mid_in_ready_low: got %b want 0", ir); end
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", ov); end
      @(negedge clk);
      tests++; if (ir !== 1'b1 || ov !== 1'b0) begin fails++; $display("FAIL mid_release: got %b/%b want 1/0", ir, ov); end
      iv = 1'b1; id = 32'h00000001; ia = 5'd1; im = ROTR; it = 4'hA;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         iv = 1'b0;
         if (ov) begin
            seen++;
            if (lat < 0) lat = c;
            tests++; if (od !== 32'h80000000 || ot !== 4'hA) begin fails++; $display("FAIL mid_result: got %h/%h want 80000000/a", od, ot); end
         end
      end
      tests++; if (seen != 1) begin fails++; $display("FAIL mid_stale: got %0d results want 1", seen); end
      tests++; if (lat != 5) begin fails++; $display("FAIL mid_latency: got %0d want 5", lat); end
   endtask

   task automatic test_random8();
      logic [11:0] q [$];
      logic [11:0] e;
      int lat, acc;
      lat = -1; acc = 0;
      @(negedge clk);
      iv8 = 1'b1; id8 = 8'hB4; ia8 = 3'd3; im8 = 3'd0; it8 = 4'h6; ordy8 = 1'b1;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         @(negedge clk);
         iv8 = 1'b0;
         if (ov8) begin
            lat = c;
            tests++; if (od8 !== 8'h96 || ot8 !== 4'h6) begin fails++; $display("FAIL r8_first: got %h/%h want 96/6", od8, ot8); end
         end
      end
      tests++; if (lat != 3) begin fails++; $display("FAIL r8_latency: got %0d want 3", lat); end
      for (int c = 0; c < 3000 && (acc < 150 || q.size() > 0); c++) begin
         @(negedge clk);
         ordy8 = ($urandom_range(0, 3) != 0);
         iv8 = (acc < 150) && ($urandom_range(0, 2) != 0);
         id8 = 8'($urandom); ia8 = 3'($urandom); im8 = 3'($urandom); it8 = 4'($urandom);
         #1;
         if (ov8 && ordy8) begin
            tests++;
            if (q.size() == 0) begin fails++; $display("FAIL r8_extra: got %h/%h want none", od8, ot8); end
            else begin
               e = q.pop_front();
               if ({od8, ot8} !== e) begin fails++; $display("FAIL r8_result: got %h/%h want %h/%h", od8, ot8, e[11:4], e[3:0]); end
            end
         end
         if (iv8 && ir8) begin
            q.push_back({ref8(id8, ia8, im8), it8});
            acc++;
         end
      end
      iv8 = 1'b0; ordy8 = 1'b1;
      tests++; if (acc != 150 || q.size() != 0) begin fails++; $display("FAIL r8_drain: got %0d accepted %0d pending want 150/0", acc, q.size()); end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rotr();
      test_back_to_back();
      test_backpressure();
      test_boundaries();
      test_reset_midflight();
      test_random8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rot_pipe.md
ROT_PIPE -- requirements
Module: rot_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter TAG_W, default 4: width of the opaque sideband tag carried with each request.
REQ-003 Derived constant LEVELS = clog2(WIDTH): shift-amount width and pipeline depth; 5 at WIDTH=32.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted on a clk edge where in_valid && in_ready.
REQ-008 in_data  in  WIDTH  operand.
REQ-009 in_amt  in  LEVELS  shift/rotate amount, 0..WIDTH-1.
REQ-010 in_mode  in  3  operation, rot_mode_t.
REQ-011 in_tag  in  TAG_W  sideband tag, returned unchanged.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result when out_valid && out_ready.
REQ-014 out_data  out  WIDTH  result.
REQ-015 out_tag  out  TAG_W  tag of the request producing out_data.

Function
REQ-016 Modes: ROTR=0 rotate right; ROTL=1 rotate left; SHR=2 logical right, zero fill; SHL=3 logical left, zero fill; SAR=4 arithmetic right, fill with in_data[WIDTH-1]; codes 5..7 SHALL pass in_data through unchanged.
REQ-017 in_amt=0 SHALL return in_data unchanged for every mode.
REQ-018 The datapath SHALL have LEVELS registered stages; stage k applies a 2^k-bit step when bit k of the amount is set.
REQ-019 Latency SHALL be exactly LEVELS cycles from acceptance to out_valid when out_ready stays high.
REQ-020 Advance condition adv = !out_valid || out_ready; in_ready SHALL equal adv whenever rst_n is high.
REQ-021 When adv is high, every stage register, including its valid bit, SHALL load from its predecessor; stage 0 SHALL load in_valid && in_ready.
REQ-022 When adv is low, all stage registers, out_data and out_tag SHALL hold; out_valid SHALL stay high.
REQ-023 Bubbles SHALL propagate as invalid stages; throughput SHALL be one result per cycle with out_ready held high.
REQ-024 Mode, amount and tag SHALL travel with the data through every stage; results SHALL leave in acceptance order.
REQ-025 out_data and out_tag SHALL be registered outputs with no combinational path from in_* signals.
REQ-026 in_ready SHALL depend combinationally only on out_valid and out_ready.
REQ-027 Simultaneous accept at input and drain at output in one cycle SHALL be supported with no loss or duplication.

Reset
REQ-028 While rst_n is low at a clk edge, all stage valid bits, out_valid, out_data and out_tag SHALL clear to 0.
REQ-029 in_ready SHALL be 0 while rst_n is low.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight requests; none SHALL appear after release.
REQ-031 In the first cycle after release, in_ready SHALL be 1 and out_valid SHALL be 0.

Structure
REQ-032 Package rot_pkg SHALL hold rot_mode_t (3-bit enum, REQ-016) and the stage payload struct {data, amt, mode, tag, valid}, parametrised by use.
REQ-033 One sub-module rot_stage SHALL implement a single level: parameters WIDTH and level index K; combinational step plus its register with enable adv.
REQ-034 rot_pipe SHALL instantiate LEVELS rot_stage instances in a generate loop and hold only the advance logic and port mapping.

Verification
REQ-035 WIDTH=32, ROTR, data 0x12345678, amt 13, tag 0x3, out_ready=1 -> out_data 0xB3C091A2, out_tag 0x3, exactly 5 cycles after acceptance.
REQ-036 Back-to-back: ROTL 4 -> 0x23456781; SHR 8 -> 0x00123456; SAR 4 of 0x80000000 -> 0xF8000000; SHL 31 of 0x00000003 -> 0x80000000; results in order on consecutive cycles.
REQ-037 Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0, out_data stable, no loss; raise out_ready -> all 5 results appear in order.
REQ-038 Boundaries: amt 0 in every mode -> in_data unchanged; mode 6 with data 0xDEADBEEF, amt 7 -> 0xDEADBEEF.
REQ-039 Assert rst_n low for 1 cycle with 3 requests in flight -> out_valid=0 afterwards, no stale results; next request (ROTR 1 of 0x00000001) -> 0x80000000 after 5 cycles.
REQ-040 WIDTH=8, random traffic with random out_ready, compared against a reference model -> every tag and result matches, latency 3 with out_ready held high.
